// File: rtl/block_device_arbiter.sv
// Round-robin arbiter sharing one block device among NCLIENTS requesters.
// Write data is locked to the granted client; responses are routed back by downstream tag.
module block_device_arbiter #(
    parameter int unsigned NCLIENTS         = 2,
    parameter int unsigned TAG_BITS         = 1,
    parameter int unsigned SECTOR_BITS      = 32,
    parameter int unsigned DATA_BITS        = 64,
    parameter int unsigned BEATS_PER_SECTOR = 64
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NCLIENTS-1:0]             c_req_valid,
    output logic [NCLIENTS-1:0]             c_req_ready,
    input  logic [NCLIENTS-1:0]             c_req_write,
    input  logic [NCLIENTS*SECTOR_BITS-1:0] c_req_offset,
    input  logic [NCLIENTS*SECTOR_BITS-1:0] c_req_len,
    input  logic [NCLIENTS-1:0]             c_data_valid,
    output logic [NCLIENTS-1:0]             c_data_ready,
    input  logic [NCLIENTS*DATA_BITS-1:0]   c_data_bits,
    output logic [NCLIENTS-1:0]             c_resp_valid,
    input  logic [NCLIENTS-1:0]             c_resp_ready,
    output logic [DATA_BITS-1:0]            c_resp_bits,
    output logic [SECTOR_BITS-1:0]          c_nsectors,
    output logic                            bdev_req_valid,
    input  logic                            bdev_req_ready,
    output logic                            bdev_req_write,
    output logic [SECTOR_BITS-1:0]          bdev_req_offset,
    output logic [SECTOR_BITS-1:0]          bdev_req_len,
    output logic [TAG_BITS-1:0]             bdev_req_tag,
    output logic                            bdev_data_valid,
    input  logic                            bdev_data_ready,
    output logic [DATA_BITS-1:0]            bdev_data_bits,
    output logic [TAG_BITS-1:0]             bdev_data_tag,
    input  logic                            bdev_resp_valid,
    output logic                            bdev_resp_ready,
    input  logic [DATA_BITS-1:0]            bdev_resp_data,
    input  logic [TAG_BITS-1:0]             bdev_resp_tag,
    input  logic [SECTOR_BITS-1:0]          bdev_info_nsectors,
    output logic                            err_bad_tag
);

    localparam int unsigned GW      = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
    localparam int unsigned BPS_LOG = $clog2(BEATS_PER_SECTOR);
    localparam int unsigned CNT_W   = SECTOR_BITS + BPS_LOG;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WDATA = 2'd2
    } state_t;

    state_t                 state;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          winner;
    logic [GW-1:0]          next_ptr;
    logic                   any_valid;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   req_write_q;
    logic [SECTOR_BITS-1:0] req_offset_q;
    logic [SECTOR_BITS-1:0] req_len_q;
    logic                   sel_write;
    logic [SECTOR_BITS-1:0] sel_offset;
    logic [SECTOR_BITS-1:0] sel_len;
    logic                   g_data_valid;
    logic [DATA_BITS-1:0]   g_data_bits;
    logic                   tag_ok;

    // Two passes give round-robin priority: clients at/after rr_ptr first, then the wrap-around.
    always_comb begin
        winner    = rr_ptr;
        any_valid = 1'b0;
        for (int unsigned i = 0; i < NCLIENTS; i++) begin
            if (!any_valid && i >= 32'(rr_ptr) && c_req_valid[i]) begin
                winner    = GW'(i);
                any_valid = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NCLIENTS; i++) begin
            if (!any_valid && i < 32'(rr_ptr) && c_req_valid[i]) begin
                winner    = GW'(i);
                any_valid = 1'b1;
            end
        end
        next_ptr = (winner == GW'(NCLIENTS - 1)) ? '0 : winner + GW'(1);
    end

    always_comb begin
        c_req_ready  = '0;
        c_data_ready = '0;
        sel_write    = 1'b0;
        sel_offset   = '0;
        sel_len      = '0;
        g_data_valid = 1'b0;
        g_data_bits  = '0;
        for (int unsigned i = 0; i < NCLIENTS; i++) begin
            if (GW'(i) == winner) begin
                c_req_ready[i] = reset_n && (state == IDLE) && any_valid;
                sel_write      = c_req_write[i];
                sel_offset     = c_req_offset[i*SECTOR_BITS +: SECTOR_BITS];
                sel_len        = c_req_len[i*SECTOR_BITS +: SECTOR_BITS];
            end
            if (GW'(i) == grant) begin
                c_data_ready[i] = (state == WDATA) && bdev_data_ready;
                g_data_valid    = c_data_valid[i];
                g_data_bits     = c_data_bits[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign bdev_req_valid  = (state == ISSUE);
    assign bdev_req_write  = req_write_q;
    assign bdev_req_offset = req_offset_q;
    assign bdev_req_len    = req_len_q;
    assign bdev_req_tag    = TAG_BITS'(grant);
    assign bdev_data_valid = (state == WDATA) && g_data_valid;
    assign bdev_data_bits  = g_data_bits;
    assign bdev_data_tag   = TAG_BITS'(grant);
    assign c_resp_bits     = bdev_resp_data;
    assign c_nsectors      = bdev_info_nsectors;

    // Unknown tags are accepted and dropped so a stray beat can never wedge the response channel.
    always_comb begin
        c_resp_valid    = '0;
        bdev_resp_ready = reset_n;
        tag_ok          = 1'b0;
        for (int unsigned i = 0; i < NCLIENTS; i++) begin
            if (32'(bdev_resp_tag) == i) begin
                tag_ok          = 1'b1;
                c_resp_valid[i] = reset_n && bdev_resp_valid;
                bdev_resp_ready = reset_n && c_resp_ready[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            beat_cnt     <= '0;
            req_write_q  <= 1'b0;
            req_offset_q <= '0;
            req_len_q    <= '0;
            err_bad_tag  <= 1'b0;
        end else begin
            if (bdev_resp_valid && !tag_ok) begin
                err_bad_tag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        req_write_q  <= sel_write;
                        req_offset_q <= sel_offset;
                        req_len_q    <= sel_len;
                        grant        <= winner;
                        rr_ptr       <= next_ptr;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bdev_req_ready) begin
                        if (req_write_q && req_len_q != '0) begin
                            beat_cnt <= CNT_W'(req_len_q) << BPS_LOG;
                            state    <= WDATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WDATA: begin
                    if (g_data_valid && bdev_data_ready) begin
                        beat_cnt <= beat_cnt - CNT_W'(1);
                        if (beat_cnt == CNT_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_device_arbiter.sv
// Directed bench for block_device_arbiter: two clients, 2-bit downstream tag, 64 beats per sector.
module tb_block_device_arbiter;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [1:0]   c_req_valid, c_req_ready, c_req_write;
    logic [63:0]  c_req_offset, c_req_len;
    logic [1:0]   c_data_valid, c_data_ready;
    logic [127:0] c_data_bits;
    logic [1:0]   c_resp_valid, c_resp_ready;
    logic [63:0]  c_resp_bits;
    logic [31:0]  c_nsectors;
    logic         bdev_req_valid, bdev_req_ready, bdev_req_write;
    logic [31:0]  bdev_req_offset, bdev_req_len;
    logic [1:0]   bdev_req_tag;
    logic         bdev_data_valid, bdev_data_ready;
    logic [63:0]  bdev_data_bits;
    logic [1:0]   bdev_data_tag;
    logic         bdev_resp_valid, bdev_resp_ready;
    logic [63:0]  bdev_resp_data;
    logic [1:0]   bdev_resp_tag;
    logic [31:0]  bdev_info_nsectors;
    logic         err_bad_tag;

    int checks = 0;
    int errors = 0;

    block_device_arbiter #(
        .NCLIENTS(2), .TAG_BITS(2), .SECTOR_BITS(32), .DATA_BITS(64), .BEATS_PER_SECTOR(64)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_write(c_req_write),
        .c_req_offset(c_req_offset), .c_req_len(c_req_len),
        .c_data_valid(c_data_valid), .c_data_ready(c_data_ready), .c_data_bits(c_data_bits),
        .c_resp_valid(c_resp_valid), .c_resp_ready(c_resp_ready), .c_resp_bits(c_resp_bits),
        .c_nsectors(c_nsectors),
        .bdev_req_valid(bdev_req_valid), .bdev_req_ready(bdev_req_ready),
        .bdev_req_write(bdev_req_write), .bdev_req_offset(bdev_req_offset),
        .bdev_req_len(bdev_req_len), .bdev_req_tag(bdev_req_tag),
        .bdev_data_valid(bdev_data_valid), .bdev_data_ready(bdev_data_ready),
        .bdev_data_bits(bdev_data_bits), .bdev_data_tag(bdev_data_tag),
        .bdev_resp_valid(bdev_resp_valid), .bdev_resp_ready(bdev_resp_ready),
        .bdev_resp_data(bdev_resp_data), .bdev_resp_tag(bdev_resp_tag),
        .bdev_info_nsectors(bdev_info_nsectors), .err_bad_tag(err_bad_tag)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int c, input logic wr, input logic [31:0] off, input logic [31:0] len);
        c_req_write[c]         = wr;
        c_req_offset[c*32 +: 32] = off;
        c_req_len[c*32 +: 32]    = len;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        c_req_valid = 2'b11; c_req_write = '0; c_req_offset = '0; c_req_len = '0;
        c_data_valid = 2'b11; c_data_bits = '0; c_resp_ready = 2'b11;
        bdev_req_ready = 1'b1; bdev_data_ready = 1'b1;
        bdev_resp_valid = 1'b1; bdev_resp_tag = 2'd0; bdev_resp_data = 64'h55;
        bdev_info_nsectors = 32'd4096;
        #3;
        checks++;
        if (c_req_ready !== 2'b00 || c_data_ready !== 2'b00 || c_resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b data_ready=%b resp_valid=%b expected all 00",
                     c_req_ready, c_data_ready, c_resp_valid);
        end
        tick(); tick();
        checks++;
        if (bdev_req_valid !== 1'b0 || bdev_data_valid !== 1'b0 || err_bad_tag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: req_valid=%b data_valid=%b err=%b expected 0 0 0",
                     bdev_req_valid, bdev_data_valid, err_bad_tag);
        end
        checks++;
        if (c_nsectors !== 32'd4096) begin
            errors++;
            $display("FAIL nsectors: got %0d expected 4096", c_nsectors);
        end
        c_req_valid = '0; c_data_valid = '0; c_resp_ready = '0;
        bdev_req_ready = 1'b0; bdev_data_ready = 1'b0; bdev_resp_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        set_req(0, 1'b0, 32'd0, 32'd1);
        set_req(1, 1'b0, 32'd8, 32'd1);
        c_req_valid = 2'b11;
        #1;
        checks++;
        if (c_req_ready !== 2'b01) begin
            errors++; $display("FAIL rr_first_ready: got %b expected 01", c_req_ready);
        end
        tick();
        c_req_valid = 2'b10;
        #1;
        checks++;
        if (bdev_req_valid !== 1'b1 || bdev_req_offset !== 32'd0 || bdev_req_len !== 32'd1 ||
            bdev_req_write !== 1'b0 || bdev_req_tag !== 2'd0 || c_req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rr_issue0: valid=%b off=%0d len=%0d wr=%b tag=%0d rdy=%b expected 1 0 1 0 0 00",
                     bdev_req_valid, bdev_req_offset, bdev_req_len, bdev_req_write, bdev_req_tag, c_req_ready);
        end
        bdev_req_ready = 1'b1;
        tick();
        bdev_req_ready = 1'b0;
        #1;
        checks++;
        if (c_req_ready !== 2'b10 || bdev_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_second_ready: rdy=%b req_valid=%b expected 10 0", c_req_ready, bdev_req_valid);
        end
        tick();
        c_req_valid = 2'b00;
        #1;
        checks++;
        if (bdev_req_valid !== 1'b1 || bdev_req_offset !== 32'd8 || bdev_req_tag !== 2'd1) begin
            errors++;
            $display("FAIL rr_issue1: valid=%b off=%0d tag=%0d expected 1 8 1",
                     bdev_req_valid, bdev_req_offset, bdev_req_tag);
        end
        bdev_req_ready = 1'b1;
        tick();
        bdev_req_ready = 1'b0;
        c_req_valid = 2'b11;
        #1;
        checks++;
        if (c_req_ready !== 2'b01) begin
            errors++; $display("FAIL rr_ptr_wrap: got %b expected 01", c_req_ready);
        end
        c_req_valid = 2'b00;
        tick();
    endtask

    task automatic test_req_stall();
        set_req(0, 1'b0, 32'd40, 32'd3);
        set_req(1, 1'b0, 32'd77, 32'd1);
        c_req_valid = 2'b01;
        bdev_req_ready = 1'b0;
        tick();
        c_req_valid = 2'b10;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (bdev_req_valid !== 1'b1 || bdev_req_offset !== 32'd40 || bdev_req_len !== 32'd3 ||
                bdev_req_tag !== 2'd0 || bdev_req_write !== 1'b0 || c_req_ready !== 2'b00) begin
                errors++;
                $display("FAIL req_stall cycle %0d: valid=%b off=%0d len=%0d tag=%0d rdy=%b expected 1 40 3 0 00",
                         k, bdev_req_valid, bdev_req_offset, bdev_req_len, bdev_req_tag, c_req_ready);
            end
            tick();
        end
        c_req_valid = 2'b00;
        bdev_req_ready = 1'b1;
        tick();
        bdev_req_ready = 1'b0;
        #1;
        checks++;
        if (bdev_req_valid !== 1'b0) begin
            errors++; $display("FAIL req_stall_release: valid=%b expected 0", bdev_req_valid);
        end
    endtask

    task automatic test_write_burst();
        int beats = 0;
        int cyc = 0;
        logic exp_v;
        set_req(1, 1'b1, 32'd100, 32'd2);
        c_req_valid = 2'b10;
        #1;
        checks++;
        if (c_req_ready !== 2'b10) begin
            errors++; $display("FAIL wr_accept: got %b expected 10", c_req_ready);
        end
        tick();
        c_req_valid = 2'b00;
        bdev_req_ready = 1'b1;
        #1;
        checks++;
        if (bdev_req_valid !== 1'b1 || bdev_req_write !== 1'b1 || bdev_req_tag !== 2'd1 || bdev_req_len !== 32'd2) begin
            errors++;
            $display("FAIL wr_issue: valid=%b wr=%b tag=%0d len=%0d expected 1 1 1 2",
                     bdev_req_valid, bdev_req_write, bdev_req_tag, bdev_req_len);
        end
        tick();
        bdev_req_ready = 1'b0;
        set_req(0, 1'b0, 32'd900, 32'd1);
        c_req_valid = 2'b01;
        c_data_bits[63:0] = 64'hDEAD;
        c_data_valid[0] = 1'b1;
        bdev_data_ready = 1'b1;
        while (beats < 128 && cyc < 200) begin
            exp_v = (cyc != 5);
            c_data_valid[1] = exp_v;
            c_data_bits[127:64] = 64'hA000 + 64'(beats);
            #1;
            checks++;
            if (bdev_data_valid !== exp_v || c_data_ready !== 2'b10 || c_req_ready !== 2'b00 ||
                (exp_v && (bdev_data_bits !== 64'hA000 + 64'(beats) || bdev_data_tag !== 2'd1))) begin
                errors++;
                $display("FAIL wr_beat %0d: valid=%b rdy=%b req_rdy=%b data=%h tag=%0d expected %b 10 00 %h 1",
                         beats, bdev_data_valid, c_data_ready, c_req_ready, bdev_data_bits,
                         bdev_data_tag, exp_v, 64'hA000 + 64'(beats));
            end
            if (exp_v) beats++;
            cyc++;
            tick();
        end
        checks++;
        if (beats != 128) begin
            errors++; $display("FAIL wr_beat_budget: got %0d beats expected 128", beats);
        end
        #1;
        checks++;
        if (bdev_data_valid !== 1'b0 || c_data_ready !== 2'b00 || c_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL wr_end: data_valid=%b data_rdy=%b req_rdy=%b expected 0 00 01",
                     bdev_data_valid, c_data_ready, c_req_ready);
        end
        tick();
        c_data_valid = 2'b00;
        c_req_valid = 2'b00;
        #1;
        checks++;
        if (bdev_req_valid !== 1'b1 || bdev_req_tag !== 2'd0 || bdev_req_offset !== 32'd900) begin
            errors++;
            $display("FAIL wr_next_req: valid=%b tag=%0d off=%0d expected 1 0 900",
                     bdev_req_valid, bdev_req_tag, bdev_req_offset);
        end
        bdev_req_ready = 1'b1;
        tick();
        bdev_req_ready = 1'b0;
        bdev_data_ready = 1'b0;
    endtask

    task automatic test_write_len0();
        set_req(1, 1'b1, 32'd200, 32'd0);
        c_req_valid = 2'b10;
        tick();
        set_req(0, 1'b0, 32'd300, 32'd1);
        c_req_valid = 2'b01;
        c_data_valid = 2'b11;
        bdev_data_ready = 1'b1;
        bdev_req_ready = 1'b1;
        #1;
        checks++;
        if (bdev_req_valid !== 1'b1 || bdev_req_write !== 1'b1 || bdev_req_len !== 32'd0 || bdev_req_tag !== 2'd1) begin
            errors++;
            $display("FAIL len0_issue: valid=%b wr=%b len=%0d tag=%0d expected 1 1 0 1",
                     bdev_req_valid, bdev_req_write, bdev_req_len, bdev_req_tag);
        end
        tick();
        bdev_req_ready = 1'b0;
        #1;
        checks++;
        if (bdev_data_valid !== 1'b0 || c_data_ready !== 2'b00 || c_req_ready !== 2'b01 || bdev_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0_idle: data_valid=%b data_rdy=%b req_rdy=%b req_valid=%b expected 0 00 01 0",
                     bdev_data_valid, c_data_ready, c_req_ready, bdev_req_valid);
        end
        c_req_valid = 2'b00;
        c_data_valid = 2'b00;
        bdev_data_ready = 1'b0;
        tick();
    endtask

    task automatic test_responses();
        logic [1:0]  tags [3];
        logic [63:0] datas [3];
        logic [63:0] got0 [$];
        logic [63:0] got1 [$];
        int idx = 0;
        int cyc = 0;
        logic exp_rdy;
        tags[0] = 2'd1; tags[1] = 2'd0; tags[2] = 2'd1;
        datas[0] = 64'h111; datas[1] = 64'h222; datas[2] = 64'h333;
        while (idx < 3 && cyc < 20) begin
            c_resp_ready = {(cyc >= 3), 1'b1};
            bdev_resp_valid = 1'b1;
            bdev_resp_tag = tags[idx];
            bdev_resp_data = datas[idx];
            exp_rdy = (tags[idx] == 2'd0) ? 1'b1 : (cyc >= 3);
            #1;
            checks++;
            if (c_resp_valid !== ((tags[idx] == 2'd0) ? 2'b01 : 2'b10) || bdev_resp_ready !== exp_rdy ||
                c_resp_bits !== datas[idx]) begin
                errors++;
                $display("FAIL resp_route cycle %0d: valid=%b rdy=%b bits=%h expected tag %0d rdy %b bits %h",
                         cyc, c_resp_valid, bdev_resp_ready, c_resp_bits, tags[idx], exp_rdy, datas[idx]);
            end
            if (c_resp_valid[0] && c_resp_ready[0]) got0.push_back(c_resp_bits);
            if (c_resp_valid[1] && c_resp_ready[1]) got1.push_back(c_resp_bits);
            if (bdev_resp_ready) idx++;
            cyc++;
            tick();
        end
        bdev_resp_valid = 1'b0;
        checks++;
        if (idx != 3 || cyc != 6) begin
            errors++; $display("FAIL resp_progress: consumed %0d in %0d cycles expected 3 in 6", idx, cyc);
        end
        checks++;
        if (got0.size() != 1 || got0[0] !== 64'h222) begin
            errors++; $display("FAIL resp_client0: got %0d beats expected 1 beat 222", got0.size());
        end
        checks++;
        if (got1.size() != 2 || got1[0] !== 64'h111 || got1[1] !== 64'h333) begin
            errors++; $display("FAIL resp_client1: got %0d beats expected 111 then 333", got1.size());
        end
    endtask

    task automatic test_bad_tag();
        #1;
        checks++;
        if (err_bad_tag !== 1'b0) begin
            errors++; $display("FAIL bad_tag_pre: err=%b expected 0", err_bad_tag);
        end
        c_resp_ready = 2'b00;
        bdev_resp_valid = 1'b1;
        bdev_resp_tag = 2'd3;
        #1;
        checks++;
        if (bdev_resp_ready !== 1'b1 || c_resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL bad_tag_drop: rdy=%b valid=%b expected 1 00", bdev_resp_ready, c_resp_valid);
        end
        tick();
        bdev_resp_valid = 1'b0;
        #1;
        checks++;
        if (err_bad_tag !== 1'b1) begin
            errors++; $display("FAIL bad_tag_set: err=%b expected 1", err_bad_tag);
        end
        tick();
        checks++;
        if (err_bad_tag !== 1'b1) begin
            errors++; $display("FAIL bad_tag_sticky: err=%b expected 1", err_bad_tag);
        end
    endtask

    task automatic test_reset_mid_wdata();
        set_req(0, 1'b1, 32'd500, 32'd1);
        c_req_valid = 2'b01;
        tick();
        c_req_valid = 2'b00;
        bdev_req_ready = 1'b1;
        tick();
        bdev_req_ready = 1'b0;
        c_data_valid = 2'b01;
        bdev_data_ready = 1'b1;
        for (int b = 0; b < 30; b++) begin
            c_data_bits[63:0] = 64'hB000 + 64'(b);
            #1;
            checks++;
            if (bdev_data_valid !== 1'b1 || bdev_data_bits !== 64'hB000 + 64'(b) || bdev_data_tag !== 2'd0) begin
                errors++;
                $display("FAIL mid_beat %0d: valid=%b data=%h tag=%0d expected 1 %h 0",
                         b, bdev_data_valid, bdev_data_bits, bdev_data_tag, 64'hB000 + 64'(b));
            end
            tick();
        end
        set_req(1, 1'b0, 32'd600, 32'd1);
        c_req_valid = 2'b10;
        c_resp_ready = 2'b11;
        bdev_resp_valid = 1'b1;
        bdev_resp_tag = 2'd1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bdev_data_valid !== 1'b0 || c_data_ready !== 2'b00 || c_req_ready !== 2'b00 ||
            c_resp_valid !== 2'b00 || bdev_req_valid !== 1'b0 || err_bad_tag !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: dv=%b dr=%b rr=%b rv=%b qv=%b err=%b expected all 0",
                     bdev_data_valid, c_data_ready, c_req_ready, c_resp_valid, bdev_req_valid, err_bad_tag);
        end
        bdev_resp_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (bdev_data_valid !== 1'b0 || c_req_ready !== 2'b10) begin
            errors++;
            $display("FAIL post_reset: data_valid=%b req_rdy=%b expected 0 10", bdev_data_valid, c_req_ready);
        end
        tick();
        c_req_valid = 2'b00;
        #1;
        checks++;
        if (bdev_req_valid !== 1'b1 || bdev_req_tag !== 2'd1 || bdev_req_offset !== 32'd600 || bdev_req_write !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_issue: valid=%b tag=%0d off=%0d wr=%b expected 1 1 600 0",
                     bdev_req_valid, bdev_req_tag, bdev_req_offset, bdev_req_write);
        end
        bdev_req_ready = 1'b1;
        tick();
        bdev_req_ready = 1'b0;
        #1;
        checks++;
        if (bdev_req_valid !== 1'b0 || bdev_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_done: req_valid=%b data_valid=%b expected 0 0", bdev_req_valid, bdev_data_valid);
        end
        c_data_valid = 2'b00;
        bdev_data_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_req_stall();
        test_write_burst();
        test_write_len0();
        test_responses();
        test_bad_tag();
        test_reset_mid_wdata();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
